// File: rtl/countdown_state_ctrl.sv
// countdown_state_ctrl
//   Sequencer for the VGA countdown display: MM:SS BCD countdown, 3-bit state
//   code and a free-running blink square wave. All outputs are registered.
//
//   Ports
//     clk, reset                   clock, synchronous active-high reset
//     arm, start, stop, clear      single-cycle button pulses
//     preset_d0..preset_d3         BCD preset MM:SS (latched and clamped on arm)
//     actualState                  000 INICIAL, 001 ESTABLE, 010 CONTANDO,
//                                  011 DETENIDO, 101 FINAL
//     dig0..dig3                   BCD count, shown as dig0 dig1 : dig2 dig3
//     finish                       high while in FINAL
//     clk1Hz                       square wave, period TICK_DIV, 50% duty
//     tick_1s                      one-cycle pulse on each decrement
module countdown_state_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] preset_d0,
  input  logic [3:0] preset_d1,
  input  logic [3:0] preset_d2,
  input  logic [3:0] preset_d3,
  output logic [2:0] actualState,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       finish,
  output logic       clk1Hz,
  output logic       tick_1s
);

  localparam int          CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(TICK_DIV / 2);

  typedef enum logic [2:0] {
    ST_INICIAL  = 3'b000,
    ST_ESTABLE  = 3'b001,
    ST_CONTANDO = 3'b010,
    ST_DETENIDO = 3'b011,
    ST_FINAL    = 3'b101
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [CW-1:0] sec_q, sec_d;
  logic [3:0]    d0_q, d1_q, d2_q, d3_q;
  logic [3:0]    d0_d, d1_d, d2_d, d3_d;
  logic          clk1hz_q, clk1hz_d;
  logic          tick_q, tick_d;
  logic          finish_q, finish_d;

  // BCD decrement of the current count, borrowing seconds units -> seconds
  // tens (base 6) -> minutes units -> minutes tens.
  logic [3:0] dec0, dec1, dec2, dec3;
  logic       cnt_zero, cnt_one;

  always_comb begin
    dec0 = d0_q;
    dec1 = d1_q;
    dec2 = d2_q;
    dec3 = d3_q;
    if (d3_q != 4'd0) begin
      dec3 = d3_q - 4'd1;
    end else begin
      dec3 = 4'd9;
      if (d2_q != 4'd0) begin
        dec2 = d2_q - 4'd1;
      end else begin
        dec2 = 4'd5;
        if (d1_q != 4'd0) begin
          dec1 = d1_q - 4'd1;
        end else begin
          dec1 = 4'd9;
          dec0 = d0_q - 4'd1;
        end
      end
    end
  end

  assign cnt_zero = (d0_q == 4'd0) && (d1_q == 4'd0) && (d2_q == 4'd0) && (d3_q == 4'd0);
  assign cnt_one  = (d0_q == 4'd0) && (d1_q == 4'd0) && (d2_q == 4'd0) && (d3_q == 4'd1);

  always_comb begin
    // Blink prescaler runs regardless of state; clk1Hz follows the next value
    // so it is aligned with the registered prescaler.
    presc_d  = (presc_q == LAST) ? '0 : presc_q + CW'(1);
    clk1hz_d = (presc_d < HALF);

    state_d = state_q;
    sec_d   = sec_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    tick_d  = 1'b0;

    if (clear) begin
      state_d = ST_INICIAL;
      {d0_d, d1_d, d2_d, d3_d} = '0;
    end else begin
      unique case (state_q)
        ST_INICIAL: begin
          if (arm) begin
            state_d = ST_ESTABLE;
            d0_d = (preset_d0 > 4'd9) ? 4'd9 : preset_d0;
            d1_d = (preset_d1 > 4'd9) ? 4'd9 : preset_d1;
            d2_d = (preset_d2 > 4'd5) ? 4'd5 : preset_d2;
            d3_d = (preset_d3 > 4'd9) ? 4'd9 : preset_d3;
          end
        end
        ST_ESTABLE: begin
          if (start) begin
            sec_d   = '0;
            state_d = cnt_zero ? ST_FINAL : ST_CONTANDO;
          end
        end
        ST_CONTANDO: begin
          // stop wins over a tick due on the same edge
          if (stop) begin
            state_d = ST_DETENIDO;
          end else if (sec_q == LAST) begin
            sec_d = '0;
            if (!cnt_zero) begin
              tick_d = 1'b1;
              {d0_d, d1_d, d2_d, d3_d} = {dec0, dec1, dec2, dec3};
              if (cnt_one) state_d = ST_FINAL;
            end
          end else begin
            sec_d = sec_q + CW'(1);
          end
        end
        ST_DETENIDO: begin
          if (start) begin
            sec_d   = '0;
            state_d = ST_CONTANDO;
          end
        end
        ST_FINAL: begin
        end
        default: begin
          // unused encodings recover to idle
          state_d = ST_INICIAL;
          {d0_d, d1_d, d2_d, d3_d} = '0;
        end
      endcase
    end

    finish_d = (state_d == ST_FINAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INICIAL;
      presc_q  <= '0;
      sec_q    <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      d3_q     <= '0;
      clk1hz_q <= 1'b0;
      tick_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      d3_q     <= d3_d;
      clk1hz_q <= clk1hz_d;
      tick_q   <= tick_d;
      finish_q <= finish_d;
    end
  end

  assign actualState = state_q;
  assign dig0        = d0_q;
  assign dig1        = d1_q;
  assign dig2        = d2_q;
  assign dig3        = d3_q;
  assign finish      = finish_q;
  assign clk1Hz      = clk1hz_q;
  assign tick_1s     = tick_q;

endmodule

// File: tb/tb_countdown_state_ctrl.sv
// Bench for countdown_state_ctrl with TICK_DIV=10. A behavioural model keeps
// the count as total seconds and the time since counting began in cycles.
module tb_countdown_state_ctrl;

  localparam int T = 10;
  localparam int S_INI = 0, S_EST = 1, S_CNT = 2, S_DET = 3, S_FIN = 5;

  logic       clk = 1'b0;
  logic       reset, arm, start, stop, clear;
  logic [3:0] preset_d0, preset_d1, preset_d2, preset_d3;
  logic [2:0] actualState;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       finish, clk1Hz, tick_1s;

  int checks = 0;
  int errors = 0;

  // reference model
  int m_state, m_secs, m_run, m_k, m_tick, m_finish;

  countdown_state_ctrl #(.TICK_DIV(T)) dut (
    .clk(clk), .reset(reset), .arm(arm), .start(start), .stop(stop), .clear(clear),
    .preset_d0(preset_d0), .preset_d1(preset_d1), .preset_d2(preset_d2), .preset_d3(preset_d3),
    .actualState(actualState), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .finish(finish), .clk1Hz(clk1Hz), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] secs_to_bcd(int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic logic exp_blink();
    return (m_k == 0) ? 1'b0 : ((m_k % T) < T / 2);
  endfunction

  function automatic logic [21:0] exp_vec();
    return {3'(m_state), secs_to_bcd(m_secs), 1'(m_finish), exp_blink(), 1'(m_tick)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {actualState, dig0, dig1, dig2, dig3, finish, clk1Hz, tick_1s};
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, sample after it.
  task automatic cycle(input logic r, input logic a, input logic s, input logic p, input logic c);
    @(negedge clk);
    reset = r; arm = a; start = s; stop = p; clear = c;
    @(posedge clk);
    m_tick = 0;
    if (r) begin
      m_state = S_INI; m_secs = 0; m_run = 0; m_k = 0;
    end else begin
      m_k++;
      if (c) begin
        m_state = S_INI; m_secs = 0;
      end else begin
        case (m_state)
          S_INI: if (a) begin
            m_secs = mn(preset_d0, 9) * 600 + mn(preset_d1, 9) * 60 +
                     mn(preset_d2, 5) * 10 + mn(preset_d3, 9);
            m_state = S_EST;
          end
          S_EST: if (s) begin
            m_run = 0;
            m_state = (m_secs == 0) ? S_FIN : S_CNT;
          end
          S_CNT: begin
            if (p) m_state = S_DET;
            else begin
              m_run++;
              if (m_run % T == 0) begin
                m_secs--; m_tick = 1;
                if (m_secs == 0) m_state = S_FIN;
              end
            end
          end
          S_DET: if (s) begin m_run = 0; m_state = S_CNT; end
          default: ;
        endcase
      end
    end
    m_finish = (m_state == S_FIN);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic set_preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    preset_d0 = a; preset_d1 = b; preset_d2 = c; preset_d3 = d;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    checks++;
    if ({actualState, dig0, dig1, dig2, dig3, finish, clk1Hz, tick_1s} !== 22'd0) begin
      errors++; $display("FAIL reset: got %h want 0", dut_vec());
    end
  endtask

  task automatic test_blink();
    int hi;
    hi = 0;
    for (int i = 0; i < 2 * T; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (clk1Hz !== exp_blink()) begin
        errors++; $display("FAIL blink k=%0d: got %b want %b", m_k, clk1Hz, exp_blink());
      end
      if (i >= T) hi += clk1Hz;
    end
    checks++;
    if (hi != T / 2) begin
      errors++; $display("FAIL blink_duty: got %0d high cycles want %0d", hi, T / 2);
    end
  endtask

  task automatic test_countdown();
    set_preset(0, 0, 0, 3);
    cycle(0, 1, 0, 0, 0);
    checks++;
    if ({actualState, dig0, dig1, dig2, dig3} !== {3'b001, 16'h0003}) begin
      errors++; $display("FAIL arm: got %b %h want 001 0003", actualState, {dig0, dig1, dig2, dig3});
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (actualState !== 3'b010) begin
      errors++; $display("FAIL start: got %b want 010", actualState);
    end
    for (int i = 1; i <= 3 * T; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (tick_1s !== (i % T == 0) || {dig0, dig1, dig2, dig3} !== secs_to_bcd(3 - i / T)) begin
        errors++;
        $display("FAIL countdown +%0d: got tick=%b dig=%h want tick=%b dig=%h",
                 i, tick_1s, {dig0, dig1, dig2, dig3}, (i % T == 0), secs_to_bcd(3 - i / T));
      end
    end
    checks++;
    if (actualState !== 3'b101 || finish !== 1'b1) begin
      errors++; $display("FAIL final: got %b fin=%b want 101 fin=1", actualState, finish);
    end
    idle(3);
    checks++;
    if (actualState !== 3'b101 || {dig0, dig1, dig2, dig3} !== 16'h0000 || tick_1s !== 1'b0) begin
      errors++; $display("FAIL final_hold: got %b %h tick=%b", actualState, {dig0, dig1, dig2, dig3}, tick_1s);
    end
  endtask

  task automatic test_borrow();
    cycle(0, 0, 0, 0, 1);
    set_preset(0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(T);
    checks++;
    if ({dig0, dig1, dig2, dig3} !== 16'h0059 || tick_1s !== 1'b1) begin
      errors++; $display("FAIL borrow_min: got %h tick=%b want 0059 tick=1", {dig0, dig1, dig2, dig3}, tick_1s);
    end
    cycle(0, 0, 0, 0, 1);
    set_preset(1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(T);
    checks++;
    if ({dig0, dig1, dig2, dig3} !== 16'h0959) begin
      errors++; $display("FAIL borrow_tens: got %h want 0959", {dig0, dig1, dig2, dig3});
    end
  endtask

  task automatic test_stop_on_tick();
    cycle(0, 0, 0, 0, 1);
    set_preset(0, 0, 0, 5);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(T - 1);
    cycle(0, 0, 0, 1, 0);
    checks++;
    if (actualState !== 3'b011 || {dig0, dig1, dig2, dig3} !== 16'h0005 || tick_1s !== 1'b0) begin
      errors++; $display("FAIL stop_tick: got %b %h tick=%b want 011 0005 tick=0",
                         actualState, {dig0, dig1, dig2, dig3}, tick_1s);
    end
    idle(3);
    cycle(0, 0, 1, 0, 0);
    idle(T - 1);
    checks++;
    if (tick_1s !== 1'b0 || {dig0, dig1, dig2, dig3} !== 16'h0005) begin
      errors++; $display("FAIL resume_early: got tick=%b dig=%h", tick_1s, {dig0, dig1, dig2, dig3});
    end
    idle(1);
    checks++;
    if (tick_1s !== 1'b1 || {dig0, dig1, dig2, dig3} !== 16'h0004 || actualState !== 3'b010) begin
      errors++; $display("FAIL resume_tick: got tick=%b dig=%h st=%b want 1 0004 010",
                         tick_1s, {dig0, dig1, dig2, dig3}, actualState);
    end
  endtask

  task automatic test_zero_start();
    cycle(0, 0, 0, 0, 1);
    set_preset(0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (actualState !== 3'b101 || finish !== 1'b1 || tick_1s !== 1'b0) begin
      errors++; $display("FAIL zero_start: got %b fin=%b tick=%b want 101 1 0", actualState, finish, tick_1s);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (actualState !== 3'b000 || finish !== 1'b0 || {dig0, dig1, dig2, dig3} !== 16'h0000) begin
      errors++; $display("FAIL clear_final: got %b fin=%b dig=%h", actualState, finish, {dig0, dig1, dig2, dig3});
    end
  endtask

  task automatic test_clamp_and_clear();
    set_preset(4'hC, 4'h3, 4'h7, 4'hF);
    cycle(0, 1, 0, 0, 0);
    checks++;
    if ({dig0, dig1, dig2, dig3} !== 16'h9359) begin
      errors++; $display("FAIL clamp: got %h want 9359", {dig0, dig1, dig2, dig3});
    end
    cycle(0, 0, 1, 0, 0);
    idle(4);
    cycle(0, 0, 1, 0, 1);
    checks++;
    if (actualState !== 3'b000 || {dig0, dig1, dig2, dig3} !== 16'h0000) begin
      errors++; $display("FAIL clear_start: got %b %h want 000 0000", actualState, {dig0, dig1, dig2, dig3});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) set_preset(0, 0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 4)));
      else set_preset(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    set_preset(0, 0, 0, 0);
    m_state = S_INI; m_secs = 0; m_run = 0; m_k = 0; m_tick = 0; m_finish = 0;
    test_reset();
    test_blink();
    test_countdown();
    test_borrow();
    test_stop_on_tick();
    test_zero_start();
    test_clamp_and_clear();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
